// File: rtl/pulse_gen_pkg.sv
// ---------------------------------------------------------------------------
// pulse_gen_pkg
// Shared definitions for the pulse generator register bus: bus widths,
// register map addresses and the bus arbiter state encoding.
// ---------------------------------------------------------------------------
package pulse_gen_pkg;

  localparam int REG_ADDR_W = 7;
  localparam int REG_DATA_W = 8;

  // Register map of the pulse generator register file
  localparam logic [REG_ADDR_W-1:0] ADDR_PULSE_ENABLE   = 7'h00;
  localparam logic [REG_ADDR_W-1:0] ADDR_YEAR_H         = 7'h01;
  localparam logic [REG_ADDR_W-1:0] ADDR_YEAR_L         = 7'h02;
  localparam logic [REG_ADDR_W-1:0] ADDR_MONTH          = 7'h03;
  localparam logic [REG_ADDR_W-1:0] ADDR_DAY            = 7'h04;
  localparam logic [REG_ADDR_W-1:0] ADDR_HOUR           = 7'h05;
  localparam logic [REG_ADDR_W-1:0] ADDR_MINUTES        = 7'h06;
  localparam logic [REG_ADDR_W-1:0] ADDR_SECONDS        = 7'h07;
  localparam logic [REG_ADDR_W-1:0] ADDR_WIDTH_HIGH_3   = 7'h08;
  localparam logic [REG_ADDR_W-1:0] ADDR_WIDTH_HIGH_2   = 7'h09;
  localparam logic [REG_ADDR_W-1:0] ADDR_WIDTH_HIGH_1   = 7'h0A;
  localparam logic [REG_ADDR_W-1:0] ADDR_WIDTH_HIGH_0   = 7'h0B;
  localparam logic [REG_ADDR_W-1:0] ADDR_WIDTH_PERIOD_3 = 7'h0C;
  localparam logic [REG_ADDR_W-1:0] ADDR_WIDTH_PERIOD_2 = 7'h0D;
  localparam logic [REG_ADDR_W-1:0] ADDR_WIDTH_PERIOD_1 = 7'h0E;
  localparam logic [REG_ADDR_W-1:0] ADDR_WIDTH_PERIOD_0 = 7'h0F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_RWAIT = 2'd2
  } arb_state_t;

  // One registered bus command
  typedef struct packed {
    logic                  wr;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } bus_cmd_t;

endpackage

// File: rtl/pulse_rr_pick.sv
// ---------------------------------------------------------------------------
// pulse_rr_pick
// Combinational two-way round-robin selector with lock qualifier.
//   req    : request from port 0 (bit 0) and port 1 (bit 1)
//   ptr    : port that wins a tie
//   locked : bus is locked to owner; only owner's request is considered
//   owner  : current/last bus owner
//   winner : selected port
//   valid  : a winner exists this cycle
// ---------------------------------------------------------------------------
module pulse_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       locked,
  input  logic       owner,
  output logic       winner,
  output logic       valid
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else can leave it unassigned and infer a latch.
  always_comb begin
    winner = 1'b0;
    valid  = 1'b0;
    if (locked) begin
      winner = owner;
      valid  = req[owner];
    end else begin
      valid  = |req;
      winner = (&req) ? ptr : req[1];
    end
  end

endmodule

// File: rtl/pulse_reg_arbiter.sv
// ---------------------------------------------------------------------------
// pulse_reg_arbiter
// Shares the pulse generator register bus between the host command
// interface (port 0) and the schedule sequencer (port 1). Round-robin
// arbitration, with a lock so one master can update multi-byte fields
// atomically; a lock is force-released after LOCK_MAX locked transactions.
// Ports:
//   i_clk, i_rst                 clock, async active-low reset
//   i_reqN/i_wrN/i_addrN/i_dataN command from port N, held until o_gntN
//   i_lockN                      keep ownership after the current transaction
//   o_gntN                       command accepted (1-cycle pulse)
//   o_rvalidN/o_rdataN           read completion pulse / held read data
//   o_wr/o_addr/o_data/i_rdata   register bus
//   o_owner                      current or last bus owner
//   o_lock_err                   pulse when a lock is force-released
// ---------------------------------------------------------------------------
module pulse_reg_arbiter
  import pulse_gen_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0,
  input  logic                  i_wr0,
  input  logic [REG_ADDR_W-1:0] i_addr0,
  input  logic [REG_DATA_W-1:0] i_data0,
  input  logic                  i_lock0,
  output logic                  o_gnt0,
  output logic                  o_rvalid0,
  output logic [REG_DATA_W-1:0] o_rdata0,
  input  logic                  i_req1,
  input  logic                  i_wr1,
  input  logic [REG_ADDR_W-1:0] i_addr1,
  input  logic [REG_DATA_W-1:0] i_data1,
  input  logic                  i_lock1,
  output logic                  o_gnt1,
  output logic                  o_rvalid1,
  output logic [REG_DATA_W-1:0] o_rdata1,
  output logic                  o_wr,
  output logic [REG_ADDR_W-1:0] o_addr,
  output logic [REG_DATA_W-1:0] o_data,
  input  logic [REG_DATA_W-1:0] i_rdata,
  output logic                  o_owner,
  output logic                  o_lock_err
);

  localparam int LOCK_CNT_W = $clog2(LOCK_MAX + 1);
  localparam int RD_CNT_W   = 2;

  arb_state_t            state, state_nxt;
  bus_cmd_t              cmd_q;
  logic                  owner;
  logic                  ptr;
  logic                  locked;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic [LOCK_CNT_W-1:0] lock_cnt_nxt;
  logic [RD_CNT_W-1:0]   rd_cnt;
  logic                  pick_winner;
  logic                  pick_valid;
  logic                  owner_lock;
  logic                  rd_last;

  pulse_rr_pick u_pick (
    .req    ({i_req1, i_req0}),
    .ptr    (ptr),
    .locked (locked),
    .owner  (owner),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign owner_lock   = owner ? i_lock1 : i_lock0;
  assign lock_cnt_nxt = lock_cnt + LOCK_CNT_W'(1);
  assign rd_last      = (rd_cnt == '0);

  // State register
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (pick_valid) state_nxt = ST_XFER;
      ST_XFER:  state_nxt = cmd_q.wr ? ST_IDLE : ST_RWAIT;
      ST_RWAIT: if (rd_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_wr   = 1'b0;
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (state == ST_XFER) begin
      o_wr   = cmd_q.wr;
      o_gnt0 = ~owner;
      o_gnt1 = owner;
    end
  end

  // Address and data hold their last values outside XFER
  assign o_addr  = cmd_q.addr;
  assign o_data  = cmd_q.data;
  assign o_owner = owner;

  // Command capture, pointer/lock bookkeeping and read completion
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cmd_q      <= '0;
      owner      <= 1'b0;
      ptr        <= 1'b0;
      locked     <= 1'b0;
      lock_cnt   <= '0;
      rd_cnt     <= '0;
      o_rvalid0  <= 1'b0;
      o_rvalid1  <= 1'b0;
      o_rdata0   <= '0;
      o_rdata1   <= '0;
      o_lock_err <= 1'b0;
    end else begin
      o_rvalid0  <= 1'b0;
      o_rvalid1  <= 1'b0;
      o_lock_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner <= pick_winner;
            cmd_q <= pick_winner ? bus_cmd_t'{i_wr1, i_addr1, i_data1}
                                 : bus_cmd_t'{i_wr0, i_addr0, i_data0};
          end
        end
        ST_XFER: begin
          // The other port wins the next tie whether or not a lock follows;
          // while locked the pointer is simply not consulted.
          ptr    <= ~owner;
          rd_cnt <= RD_CNT_W'(RD_LATENCY - 1);
          if (owner_lock && (lock_cnt_nxt != LOCK_CNT_W'(LOCK_MAX))) begin
            locked   <= 1'b1;
            lock_cnt <= lock_cnt_nxt;
          end else begin
            locked     <= 1'b0;
            lock_cnt   <= '0;
            o_lock_err <= owner_lock;
          end
        end
        ST_RWAIT: begin
          if (rd_last) begin
            if (owner) begin
              o_rdata1  <= i_rdata;
              o_rvalid1 <= 1'b1;
            end else begin
              o_rdata0  <= i_rdata;
              o_rvalid0 <= 1'b1;
            end
          end else begin
            rd_cnt <= rd_cnt - RD_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
